// File: rtl/fifo_to_axi4s_pkt.sv
// FWFT FIFO read side to AXI4-Stream master with fixed-length packets.
// Optional pad-flush of stalled partial packets: FIFO_TO_AXIS_TIMEOUT_EN.
module fifo_to_axi4s_pkt #(
    parameter int                DATA_W   = 32,
    parameter int                PKT_LEN  = 1024,
    parameter int                CNT_W    = 16,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [1:0]        m_axis_tuser,
    output logic              pkt_done,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] PAD    = 2'd2;

    localparam logic [CNT_W-1:0] WLAST = CNT_W'(PKT_LEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wcnt;
    logic             load;
    logic             pop;
    logic             fill;
    logic             wlast;
    logic             hs_last;
    logic             timeout_hit;

    assign load    = !m_axis_tvalid || m_axis_tready;
    assign pop     = (state == STREAM) && !fifo_empty && load;
    assign wlast   = (wcnt == WLAST);
    assign hs_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    assign fifo_rd_en = pop;

`ifdef FIFO_TO_AXIS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] idle_cnt;
    logic        idle_run;

    // Counts only while a partial packet is starved of FIFO data
    assign idle_run    = (state == STREAM) && (wcnt != '0) && fifo_empty;
    assign timeout_hit = idle_run && (idle_cnt == TO_LAST);
    assign fill        = (state == PAD) && load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (pop || timeout_hit) begin
            idle_cnt <= '0;
        end else if (idle_run) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign fill           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 2'b00;
            wcnt          <= '0;
        end else if (pop || fill) begin
            m_axis_tdata  <= pop ? fifo_dout : PAD_WORD;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= wlast;
            m_axis_tuser  <= {fill, (wcnt == '0)};
            wcnt          <= wlast ? '0 : wcnt + 1'b1;
        end else if (load) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            pkt_done <= hs_last;
            if (hs_last) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    // en only matters in IDLE and on the load that closes a packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) state <= STREAM;
                end
                STREAM: begin
                    if (pop && wlast && !en) state <= IDLE;
                    else if (timeout_hit)    state <= PAD;
                end
                PAD: begin
                    if (fill && wlast) state <= en ? STREAM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_to_axi4s_pkt.sv
// Scoreboard bench for fifo_to_axi4s_pkt with a queue-based FIFO.
// Pad-flush scenario is exercised when FIFO_TO_AXIS_TIMEOUT_EN is defined.
module tb_fifo_to_axi4s_pkt;

    localparam int PKT_LEN = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout  = '0;
    logic        fifo_rd_en;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tuser;
    logic        pkt_done;
    logic [15:0] pkt_cnt;

    logic [31:0] fifo_q[$];
    beat_t       exp_q[$];
    int          pos;
    int          exp_pkts;
    int          done_seen;
    int          hs_cnt;
    int          tests;
    int          fails;
    int          rdy_mode;

    fifo_to_axi4s_pkt #(
        .DATA_W  (32),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (16),
        .TIMEOUT (8),
        .PAD_WORD(32'hDEAD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .pkt_done     (pkt_done),
        .pkt_cnt      (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // FWFT FIFO: head and empty flag change only after a clock edge
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) chk("pop_on_empty", 1, 0);
            else void'(fifo_q.pop_front());
        end
        fifo_empty <= (fifo_q.size() == 0);
        fifo_dout  <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    end

    always @(negedge clk) begin
        unique case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: sampled mid-cycle, describes the handshake at the next edge
    logic  prev_stall;
    logic  prev_lhs;
    beat_t prev_b;
    initial begin
        beat_t b;
        beat_t cur;
        prev_stall = 1'b0;
        prev_lhs   = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
                prev_lhs   = 1'b0;
            end else begin
                cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
                if (pkt_done || prev_lhs) chk("pkt_done", pkt_done, prev_lhs);
                if (pkt_done) done_seen++;
                if (prev_stall) chk("stall_hold", {m_axis_tvalid, cur},
                                    {1'b1, prev_b});
                if (m_axis_tvalid && !m_axis_tready)
                    chk("rd_en_in_stall", fifo_rd_en, 0);
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", cur, 0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", m_axis_tdata, b.d);
                        chk("beat_last", m_axis_tlast, b.last);
                        chk("beat_user", m_axis_tuser, b.user);
                    end
                end
                prev_lhs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_b     = cur;
            end
        end
    end

    function automatic beat_t mk(input logic [31:0] d, input logic pad);
        beat_t b;
        b.d    = d;
        b.last = (pos == PKT_LEN - 1);
        b.user = {pad, (pos == 0)};
        if (pos == PKT_LEN - 1) exp_pkts++;
        pos = (pos + 1) % PKT_LEN;
        return b;
    endfunction

    task automatic push_exp(input logic [31:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(mk(d, 1'b0));
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_axis_tvalid) ok = 1;
        end
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tvalid"}, m_axis_tvalid, 0);
        chk({nm, "_tdata"}, m_axis_tdata, 0);
        chk({nm, "_tlast"}, m_axis_tlast, 0);
        chk({nm, "_tuser"}, m_axis_tuser, 0);
        chk({nm, "_done"}, pkt_done, 0);
        chk({nm, "_cnt"}, pkt_cnt, 0);
        chk({nm, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;
        tests = 0; fails = 0; pos = 0; exp_pkts = 0;
        done_seen = 0; hs_cnt = 0; rdy_mode = 0;
        rst = 1'b1; en = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        for (int i = 0; i < 8; i++) push_exp(32'h10 + i);
        drain();
        chk("t1_pkt_cnt", pkt_cnt, 16'(exp_pkts));
        chk("t1_done_pulses", done_seen, 2);

        rdy_mode = 1;
        for (int i = 0; i < 8; i++) push_exp(32'h10 + i);
        drain();
        chk("t2_pkt_cnt", pkt_cnt, 16'(exp_pkts));

        rdy_mode = 2;
        for (int i = 0; i < 6 * PKT_LEN; i++) begin
            push_exp($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("rand_pkt_cnt", pkt_cnt, 16'(exp_pkts));

        rdy_mode = 0;
        base = hs_cnt;
        for (int i = 0; i < 12; i++) begin
            if (i < PKT_LEN) push_exp(32'h100 + i);
            else fifo_q.push_back(32'h100 + i);
        end
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (hs_cnt >= base + 2) ok = 1;
        end
        if (!ok) chk("t3_wait_timeout", hs_cnt - base, 2);
        en = 1'b0;
        drain();
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en || m_axis_tvalid) ok = 0;
        end
        chk("t3_idle_after_drop", ok, 1);
        chk("t3_fifo_left", fifo_q.size(), 8);
        chk("t3_pkt_cnt", pkt_cnt, 16'(exp_pkts));
        fifo_q.delete();
        repeat (2) @(negedge clk);
        en = 1'b1;

`ifndef FIFO_TO_AXIS_TIMEOUT_EN
        push_exp(32'hA0);
        push_exp(32'hA1);
        repeat (10) @(negedge clk);
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) ok = 0;
        end
        chk("t4_gap_tvalid_low", ok, 1);
        chk("t4_gap_pending", exp_q.size(), 0);
        push_exp(32'hA2);
        push_exp(32'hA3);
        drain();
        chk("t4_pkt_cnt", pkt_cnt, 16'(exp_pkts));
`else
        push_exp(32'hB0);
        for (int i = 1; i < PKT_LEN; i++) exp_q.push_back(mk(32'hDEAD, 1'b1));
        drain();
        chk("t5_pkt_cnt", pkt_cnt, 16'(exp_pkts));
        for (int i = 0; i < PKT_LEN; i++) push_exp(32'hC0 + i);
        drain();
        chk("t5_resume_cnt", pkt_cnt, 16'(exp_pkts));
`endif

        rdy_mode = 3;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hE0 + i);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) ok = 1;
        end
        chk("t6_tvalid_before_rst", ok, 1);
        #2 rst = 1'b1;
        #1 chk_zero("t6_async");
        fifo_q.delete();
        exp_q.delete();
        pos = 0; exp_pkts = 0; done_seen = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < PKT_LEN; i++) push_exp(32'hF0 + i);
        drain();
        chk("t6_pkt_cnt", pkt_cnt, 1);
        chk("t6_done_pulses", done_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
